sf_flash_pwr_sequencer: RTL and testbench

- Clocked power-up and reset sequencer for the simulated serial-flash devices in the SF-Tester benches.
- Per channel, drives the model's 32-bit Vcc (mV) as a ramp, holds the model in power-up wait, pulses RESET#, then gates chip-select until the device is ready.
- Supports N devices, step or ramped Vcc, and brown-out injection with automatic re-sequencing. Sits between the VHDL test-bench and the flash model instances.

---
 rtl/sf_pwr_seq_pkg.sv | 26 ++
 rtl/sf_pwr_seq_chan.sv | 130 +++++++++++++
 rtl/sf_flash_pwr_sequencer.sv | 59 +++++
 tb/tb_sf_flash_pwr_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sf_pwr_seq_pkg.sv
// Shared types and constants for the serial-flash power sequencer.
// Imported by the per-channel FSM and by the top-level wrapper.
package sf_pwr_seq_pkg;

   localparam int VCC_W     = 32;
   localparam int SEQ_CNT_W = 8;

   typedef enum logic [2:0] {
      OFF,
      RAMP,
      WAIT_PWRUP,
      RESET_PULSE,
      READY,
      BROWNOUT
   } pwr_state_e;

   // One counter serves every timed state, so size it for the longest hold.
   function automatic int cnt_width(input int unsigned a, input int unsigned b,
                                    input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sf_pwr_seq_chan.sv
// One flash channel: Vcc ramp, power-up wait, RESET# pulse, ready gating,
// brown-out injection and automatic re-sequencing.
module sf_pwr_seq_chan
   import sf_pwr_seq_pkg::*;
#(
   parameter int unsigned VCC_TARGET_MV   = 3300,
   parameter int unsigned VCC_STEP_MV     = 100,
   parameter int unsigned PWRUP_CYCLES    = 3000,
   parameter int unsigned RESET_CYCLES    = 20,
   parameter int unsigned BROWNOUT_MV     = 2000,
   parameter int unsigned BROWNOUT_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 brownout,
   output logic [VCC_W-1:0]     vcc_mv,
   output logic                 reset_n,
   output logic                 cs_gate,
   output logic                 ready,
   output logic [SEQ_CNT_W-1:0] seq_count
);

   localparam int CNT_W = cnt_width(PWRUP_CYCLES, RESET_CYCLES, BROWNOUT_CYCLES);
   localparam logic [CNT_W-1:0] PWRUP_LAST    = CNT_W'(PWRUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LAST    = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] BROWNOUT_LAST = CNT_W'(BROWNOUT_CYCLES - 1);
   localparam logic [VCC_W-1:0] TARGET_V      = VCC_W'(VCC_TARGET_MV);
   localparam logic [VCC_W-1:0] BROWNOUT_V    = VCC_W'(BROWNOUT_MV);
   localparam logic [VCC_W:0]   STEP_EXT      = {1'b0, VCC_W'(VCC_STEP_MV)};

   pwr_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [VCC_W:0]   ramp_sum;
   logic [VCC_W-1:0] ramp_next;

   // Sum carries an extra bit so the saturation compare can never see a wrap.
   always_comb begin
      ramp_sum  = {1'b0, vcc_mv} + STEP_EXT;
      ramp_next = ramp_sum[VCC_W-1:0];
      if (VCC_STEP_MV == 0 || ramp_sum >= {1'b0, TARGET_V}) begin
         ramp_next = TARGET_V;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= OFF;
         cnt       <= '0;
         vcc_mv    <= '0;
         reset_n   <= 1'b0;
         cs_gate   <= 1'b1;
         ready     <= 1'b0;
         seq_count <= '0;
      end else if (state != OFF && !enable) begin
         state   <= OFF;
         cnt     <= '0;
         vcc_mv  <= '0;
         reset_n <= 1'b0;
         cs_gate <= 1'b1;
         ready   <= 1'b0;
      end else if (state != OFF && brownout) begin
         // Also taken while already in BROWNOUT, which restarts the hold.
         state   <= BROWNOUT;
         cnt     <= '0;
         vcc_mv  <= BROWNOUT_V;
         reset_n <= 1'b0;
         cs_gate <= 1'b1;
         ready   <= 1'b0;
      end else begin
         case (state)
            OFF: begin
               if (enable) begin
                  state <= RAMP;
                  cnt   <= '0;
               end
            end
            RAMP: begin
               vcc_mv <= ramp_next;
               if (ramp_next == TARGET_V) begin
                  state   <= WAIT_PWRUP;
                  cnt     <= '0;
                  reset_n <= 1'b1;
               end
            end
            WAIT_PWRUP: begin
               if (cnt == PWRUP_LAST) begin
                  state   <= RESET_PULSE;
                  cnt     <= '0;
                  reset_n <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESET_PULSE: begin
               if (cnt == RESET_LAST) begin
                  state     <= READY;
                  cnt       <= '0;
                  reset_n   <= 1'b1;
                  cs_gate   <= 1'b0;
                  ready     <= 1'b1;
                  seq_count <= seq_count + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            READY: begin
               cnt <= '0;
            end
            BROWNOUT: begin
               if (cnt == BROWNOUT_LAST) begin
                  state <= RAMP;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state   <= OFF;
               cnt     <= '0;
               vcc_mv  <= '0;
               reset_n <= 1'b0;
               cs_gate <= 1'b1;
               ready   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sf_flash_pwr_sequencer.sv
// Power-up/reset sequencer for NUM_DEV simulated serial-flash devices;
// one independent channel FSM per device, outputs packed per channel.
module sf_flash_pwr_sequencer
   import sf_pwr_seq_pkg::*;
#(
   parameter int          NUM_DEV         = 1,
   parameter int unsigned VCC_TARGET_MV   = 3300,
   parameter int unsigned VCC_STEP_MV     = 100,
   parameter int unsigned PWRUP_CYCLES    = 3000,
   parameter int unsigned RESET_CYCLES    = 20,
   parameter int unsigned BROWNOUT_MV     = 2000,
   parameter int unsigned BROWNOUT_CYCLES = 8
) (
   input  logic                           i_clk_20mhz,
   input  logic                           i_rstn_20mhz,
   input  logic [NUM_DEV-1:0]             i_enable,
   input  logic [NUM_DEV-1:0]             i_brownout,
   output logic [NUM_DEV*VCC_W-1:0]       o_vcc_mv,
   output logic [NUM_DEV-1:0]             o_reset_n,
   output logic [NUM_DEV-1:0]             o_cs_gate,
   output logic [NUM_DEV-1:0]             o_ready,
   output logic [NUM_DEV*SEQ_CNT_W-1:0]   o_seq_count
);

   if (NUM_DEV < 1) begin : g_bad_num_dev
      $error("NUM_DEV must be at least 1");
   end
   if (VCC_STEP_MV > VCC_TARGET_MV) begin : g_bad_step
      $error("VCC_STEP_MV must not exceed VCC_TARGET_MV");
   end
   if (BROWNOUT_MV >= VCC_TARGET_MV) begin : g_bad_brownout_mv
      $error("BROWNOUT_MV must be below VCC_TARGET_MV");
   end
   if (PWRUP_CYCLES < 1 || RESET_CYCLES < 1 || BROWNOUT_CYCLES < 1) begin : g_bad_cycles
      $error("cycle parameters must be at least 1");
   end

   for (genvar n = 0; n < NUM_DEV; n++) begin : g_chan
      sf_pwr_seq_chan #(
         .VCC_TARGET_MV   (VCC_TARGET_MV),
         .VCC_STEP_MV     (VCC_STEP_MV),
         .PWRUP_CYCLES    (PWRUP_CYCLES),
         .RESET_CYCLES    (RESET_CYCLES),
         .BROWNOUT_MV     (BROWNOUT_MV),
         .BROWNOUT_CYCLES (BROWNOUT_CYCLES)
      ) u_chan (
         .clk       (i_clk_20mhz),
         .rst_n     (i_rstn_20mhz),
         .enable    (i_enable[n]),
         .brownout  (i_brownout[n]),
         .vcc_mv    (o_vcc_mv[VCC_W*n +: VCC_W]),
         .reset_n   (o_reset_n[n]),
         .cs_gate   (o_cs_gate[n]),
         .ready     (o_ready[n]),
         .seq_count (o_seq_count[SEQ_CNT_W*n +: SEQ_CNT_W])
      );
   end

endmodule

// File: tb/tb_sf_flash_pwr_sequencer.sv
// Scoreboard bench for the flash power sequencer: a ramped two-channel
// instance and a single-channel step-mode instance, directed vectors.
module tb_sf_flash_pwr_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  enable_a, brownout_a;
   logic        enable_b, brownout_b;
   logic [63:0] vcc_a;
   logic [1:0]  reset_n_a, cs_gate_a, ready_a;
   logic [15:0] seq_a;
   logic [31:0] vcc_b;
   logic        reset_n_b, cs_gate_b, ready_b;
   logic [7:0]  seq_b;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int          cyc;
      string       name;
      int          dev;
      logic [31:0] vcc;
      logic        rn;
      logic        csg;
      logic        rdy;
      logic [7:0]  seq;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   sf_flash_pwr_sequencer #(
      .NUM_DEV(2), .VCC_TARGET_MV(3300), .VCC_STEP_MV(1000), .PWRUP_CYCLES(10),
      .RESET_CYCLES(3), .BROWNOUT_MV(2000), .BROWNOUT_CYCLES(8)
   ) dut_ramp (
      .i_clk_20mhz(clk), .i_rstn_20mhz(rstn), .i_enable(enable_a),
      .i_brownout(brownout_a), .o_vcc_mv(vcc_a), .o_reset_n(reset_n_a),
      .o_cs_gate(cs_gate_a), .o_ready(ready_a), .o_seq_count(seq_a)
   );

   sf_flash_pwr_sequencer #(
      .NUM_DEV(1), .VCC_TARGET_MV(3300), .VCC_STEP_MV(0), .PWRUP_CYCLES(10),
      .RESET_CYCLES(3), .BROWNOUT_MV(2000), .BROWNOUT_CYCLES(8)
   ) dut_step (
      .i_clk_20mhz(clk), .i_rstn_20mhz(rstn), .i_enable(enable_b),
      .i_brownout(brownout_b), .o_vcc_mv(vcc_b), .o_reset_n(reset_n_b),
      .o_cs_gate(cs_gate_b), .o_ready(ready_b), .o_seq_count(seq_b)
   );

   function automatic void expect_at(input int c, input string n, input int d,
                                     input logic [31:0] v, input logic rn,
                                     input logic csg, input logic rdy,
                                     input logic [7:0] s);
      exp_t e;
      e.cyc = c; e.name = n; e.dev = d; e.vcc = v;
      e.rn = rn; e.csg = csg; e.rdy = rdy; e.seq = s;
      sb.push_back(e);
   endfunction

   function automatic void expect_off(input int c, input string n, input int d,
                                      input logic [7:0] s);
      expect_at(c, n, d, 32'd0, 1'b0, 1'b1, 1'b0, s);
   endfunction

   function automatic void expect_ready(input int c, input string n, input int d,
                                        input logic [7:0] s);
      expect_at(c, n, d, 32'd3300, 1'b1, 1'b0, 1'b1, s);
   endfunction

   function automatic void checkOutput(input exp_t e);
      logic [31:0] v;
      logic        rn, csg, rdy;
      logic [7:0]  s;
      case (e.dev)
         0: begin v = vcc_a[31:0];  rn = reset_n_a[0]; csg = cs_gate_a[0]; rdy = ready_a[0]; s = seq_a[7:0];  end
         1: begin v = vcc_a[63:32]; rn = reset_n_a[1]; csg = cs_gate_a[1]; rdy = ready_a[1]; s = seq_a[15:8]; end
         default: begin v = vcc_b; rn = reset_n_b; csg = cs_gate_b; rdy = ready_b; s = seq_b; end
      endcase
      checks++;
      if (v !== e.vcc || rn !== e.rn || csg !== e.csg || rdy !== e.rdy || s !== e.seq) begin
         errors++;
         $display("[TB] FAIL %s cyc=%0d dev=%0d: got vcc=%0d rn=%b cs=%b rdy=%b seq=%0d, want vcc=%0d rn=%b cs=%b rdy=%b seq=%0d",
                  e.name, e.cyc, e.dev, v, rn, csg, rdy, s, e.vcc, e.rn, e.csg, e.rdy, e.seq);
      end
   endfunction

   // Monitor: compares every scoreboard entry whose cycle has arrived.
   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc == cyc) begin
            checkOutput(sb[i]);
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s dev=%0d: not sampled, now cyc=%0d, required cyc=%0d",
                     sb[i].name, sb[i].dev, cyc, sb[i].cyc);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic [1:0] ea, input logic [1:0] ba,
                                input logic eb, input logic bb);
      rstn       = r;
      enable_a   = ea;
      brownout_a = ba;
      enable_b   = eb;
      brownout_b = bb;
   endtask

   initial begin
      int k, b, k2, k3, k6, guard;

      // Reset held for 50 cycles with everything disabled.
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         expect_off(cyc + 1,  "reset_first", d, 8'd0);
         expect_off(cyc + 25, "reset_mid",   d, 8'd0);
         expect_off(cyc + 50, "reset_end",   d, 8'd0);
      end
      repeat (50) @(negedge clk);

      // Full sequence: ramped channel 0 and the step-mode device.
      applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
      k = cyc + 1;
      expect_off(k, "ramp_entry_vcc0", 0, 8'd0);
      expect_at(k + 1,  "ramp_1000",   0, 32'd1000, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_at(k + 2,  "ramp_2000",   0, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_at(k + 3,  "ramp_3000",   0, 32'd3000, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_at(k + 4,  "ramp_3300",   0, 32'd3300, 1'b1, 1'b1, 1'b0, 8'd0);
      expect_at(k + 13, "pwrup_last",  0, 32'd3300, 1'b1, 1'b1, 1'b0, 8'd0);
      expect_at(k + 14, "rst_pulse_a", 0, 32'd3300, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_at(k + 16, "rst_pulse_b", 0, 32'd3300, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_ready(k + 17, "ready_seq1", 0, 8'd1);
      expect_off(k + 5,  "ch1_idle_a", 1, 8'd0);
      expect_off(k + 17, "ch1_idle_b", 1, 8'd0);
      expect_off(k, "step_entry", 2, 8'd0);
      expect_at(k + 1,  "step_3300",     2, 32'd3300, 1'b1, 1'b1, 1'b0, 8'd0);
      expect_at(k + 10, "step_pwrup",    2, 32'd3300, 1'b1, 1'b1, 1'b0, 8'd0);
      expect_at(k + 11, "step_rst_a",    2, 32'd3300, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_at(k + 13, "step_rst_b",    2, 32'd3300, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_ready(k + 14, "step_ready", 2, 8'd1);
      repeat (20) @(negedge clk);

      // Brown-out from READY; step device gets a 3-cycle request (hold restart).
      applyStimulus(1'b1, 2'b01, 2'b01, 1'b1, 1'b1);
      b = cyc + 1;
      expect_at(b,      "bo_enter",   0, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_at(b + 7,  "bo_hold",    0, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_at(b + 8,  "bo_reramp",  0, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_at(b + 9,  "bo_3000",    0, 32'd3000, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_at(b + 10, "bo_3300",    0, 32'd3300, 1'b1, 1'b1, 1'b0, 8'd1);
      expect_at(b + 20, "bo_rst",     0, 32'd3300, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_at(b + 22, "bo_rst_end", 0, 32'd3300, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_ready(b + 23, "bo_ready_seq2", 0, 8'd2);
      expect_off(b, "bo_ch1_off", 1, 8'd0);
      expect_at(b,      "sbo_enter",   2, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_at(b + 9,  "sbo_restart", 2, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_at(b + 10, "sbo_reramp",  2, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_at(b + 11, "sbo_3300",    2, 32'd3300, 1'b1, 1'b1, 1'b0, 8'd1);
      expect_at(b + 23, "sbo_rst",     2, 32'd3300, 1'b0, 1'b1, 1'b0, 8'd1);
      expect_ready(b + 24, "sbo_ready_seq2", 2, 8'd2);
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
      repeat (24) @(negedge clk);

      // Disable, re-enable, then enable-low with brown-out mid-ramp.
      applyStimulus(1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
      expect_off(cyc + 1, "disable_off", 0, 8'd2);
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
      k2 = cyc + 1;
      expect_at(k2 + 1, "reen_1000", 0, 32'd1000, 1'b0, 1'b1, 1'b0, 8'd2);
      expect_at(k2 + 2, "reen_2000", 0, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd2);
      repeat (3) @(negedge clk);
      applyStimulus(1'b1, 2'b00, 2'b01, 1'b1, 1'b0);
      expect_off(k2 + 3, "en_low_beats_bo", 0, 8'd2);
      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
      k3 = cyc + 1;
      expect_off(k3, "reen2_entry", 0, 8'd2);
      expect_at(k3 + 1, "reen2_from0", 0, 32'd1000, 1'b0, 1'b1, 1'b0, 8'd2);
      expect_at(k3 + 4, "reen2_3300",  0, 32'd3300, 1'b1, 1'b1, 1'b0, 8'd2);
      expect_ready(k3 + 17, "reen2_seq3", 0, 8'd3);
      repeat (20) @(negedge clk);

      // Channel 1 runs and browns out while channel 0 sits in READY.
      applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
      k6 = cyc + 1;
      expect_at(k6 + 1,  "c1_1000",   1, 32'd1000, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_at(k6 + 2,  "c1_bo",     1, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_at(k6 + 10, "c1_reramp", 1, 32'd2000, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_at(k6 + 11, "c1_3000",   1, 32'd3000, 1'b0, 1'b1, 1'b0, 8'd0);
      expect_at(k6 + 12, "c1_3300",   1, 32'd3300, 1'b1, 1'b1, 1'b0, 8'd0);
      expect_at(k6 + 14, "c1_wait",   1, 32'd3300, 1'b1, 1'b1, 1'b0, 8'd0);
      expect_ready(k6 + 1,  "c0_iso_a", 0, 8'd3);
      expect_ready(k6 + 2,  "c0_iso_b", 0, 8'd3);
      expect_ready(k6 + 5,  "c0_iso_c", 0, 8'd3);
      expect_ready(k6 + 12, "c0_iso_d", 0, 8'd3);
      expect_ready(k6 + 14, "c0_iso_e", 0, 8'd3);
      expect_ready(k6 + 14, "step_hold", 2, 8'd2);
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 2'b11, 2'b10, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
      repeat (12) @(negedge clk);

      // Reset during channel 1 WAIT_PWRUP.
      applyStimulus(1'b0, 2'b11, 2'b00, 1'b1, 1'b0);
      for (int d = 0; d < 3; d++) begin
         expect_off(k6 + 15, "midseq_reset", d, 8'd0);
         expect_off(k6 + 17, "midseq_reset_hold", d, 8'd0);
      end
      repeat (5) @(negedge clk);

      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s dev=%0d: never compared, required cyc=%0d",
                  sb[0].name, sb[0].dev, sb[0].cyc);
         sb.delete(0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
